// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ word streams.
// One word is latched into a holding register and offered on a valid/ready
// master port; each word is sent whole so frames never interleave.
// Optional: define UART_ARB_BURST_EN to let one requester keep the grant for
// up to MAX_BURST consecutive words.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned W_OUT     = 24,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W_OUT-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       m_valid,
  output logic [W_OUT-1:0]           m_data,
  input  logic                       m_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  // Reject unusable parameterisations at elaboration.
  if (N_REQ < 2 || MAX_BURST < 1) begin : g_bad_params
    $error("uart_tx_arbiter: N_REQ must be >= 2 and MAX_BURST >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic               m_valid_q;
  logic [W_OUT-1:0]   m_data_q;
  logic [PTR_W-1:0]   grant_id_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [PTR_W-1:0]   ptr_adv;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [W_OUT-1:0]   win_data;
  logic               accept;
  logic               hs;
  int unsigned        idx;

`ifdef UART_ARB_BURST_EN
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CNT_W-1:0]   burst_cnt_q;
  logic [CNT_W-1:0]   burst_cnt_d;
`endif

  // Winner search starting at ptr, wrapping at N_REQ-1 (not at a power of two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req_valid[PTR_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Select the winning requester's word slice.
  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_idx == PTR_W'(k)) win_data = req_data[k*W_OUT +: W_OUT];
    end
  end

  assign accept    = (state_q == IDLE) && win_found;
  assign hs        = (state_q == HOLD) && m_ready;
  assign req_ready = (rstn && accept) ? (N_REQ'(1) << win_idx) : '0;

  // Next round-robin pointer (and burst count) after a handshake.
  always_comb begin
    ptr_adv = (grant_id_q == PTR_W'(N_REQ - 1)) ? '0 : grant_id_q + PTR_W'(1);
    ptr_d   = ptr_q;
`ifdef UART_ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
    if (hs) begin
      if (32'(burst_cnt_q) + 1 < MAX_BURST) begin
        ptr_d       = grant_id_q;
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end else begin
        ptr_d       = ptr_adv;
        burst_cnt_d = '0;
      end
    end else if (accept && (win_idx != grant_id_q)) begin
      burst_cnt_d = '0;
    end
`else
    if (hs) ptr_d = ptr_adv;
`endif
  end

  // Holding-register FSM with registered master-port outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
`ifdef UART_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef UART_ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
      case (state_q)
        IDLE: begin
          if (win_found) begin
            m_data_q   <= win_data;
            grant_id_q <= win_idx;
            m_valid_q  <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          m_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 2-requester and a 3-requester instance.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  rv2;
  logic [47:0] rd2;
  logic [1:0]  rr2;
  logic        mv2;
  logic [23:0] md2;
  logic        mr2;
  logic [0:0]  gid2;

  logic [2:0]  rv3;
  logic [71:0] rd3;
  logic [2:0]  rr3;
  logic        mv3;
  logic [23:0] md3;
  logic        mr3;
  logic [1:0]  gid3;

  int checks = 0;
  int passed = 0;
  int got[16];
  int ngot;

  uart_tx_arbiter #(.N_REQ(2), .W_OUT(24), .MAX_BURST(3)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
    .m_valid(mv2), .m_data(md2), .m_ready(mr2), .grant_id(gid2)
  );

  uart_tx_arbiter #(.N_REQ(3), .W_OUT(24), .MAX_BURST(3)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
    .m_valid(mv3), .m_data(md3), .m_ready(mr3), .grant_id(gid3)
  );

  task automatic do_reset();
    rstn = 1'b0;
    rv2 = '0; rv3 = '0; mr2 = 1'b0; mr3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Record the index of each accept on dut2 (sampled mid-cycle).
  task automatic collect2(input int n);
    ngot = 0;
    for (int c = 0; c < 400 && ngot < n; c++) begin
      @(negedge clk);
      if (rr2 != 2'b00) begin
        checks++;
        if (!$onehot(rr2)) $display("FAIL onehot2: req_ready=%b, required one-hot", rr2);
        else passed++;
        got[ngot] = rr2[1] ? 1 : 0;
        ngot++;
      end
    end
    if (ngot < n) begin
      checks++;
      $display("FAIL collect2_timeout: got %0d grants, required %0d", ngot, n);
      for (int i = ngot; i < n; i++) got[i] = -1;
    end
  endtask

  task automatic collect3(input int n);
    ngot = 0;
    for (int c = 0; c < 400 && ngot < n; c++) begin
      @(negedge clk);
      if (rr3 != 3'b000) begin
        checks++;
        if (!$onehot(rr3)) $display("FAIL onehot3: req_ready=%b, required one-hot", rr3);
        else passed++;
        got[ngot] = rr3[0] ? 0 : (rr3[1] ? 1 : 2);
        ngot++;
      end
    end
    if (ngot < n) begin
      checks++;
      $display("FAIL collect3_timeout: got %0d grants, required %0d", ngot, n);
      for (int i = ngot; i < n; i++) got[i] = -1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rv2 = '0; rv3 = '0; mr2 = 1'b0; mr3 = 1'b0; rd2 = '0; rd3 = '0;
    #3;
    checks++; if (mv2 !== 1'b0) $display("FAIL rst_mvalid: got %b, required 0", mv2); else passed++;
    checks++; if (md2 !== 24'h0) $display("FAIL rst_mdata: got %h, required 0", md2); else passed++;
    checks++; if (gid2 !== 1'b0) $display("FAIL rst_gid: got %0d, required 0", gid2); else passed++;
    checks++; if (mv3 !== 1'b0) $display("FAIL rst_mvalid3: got %b, required 0", mv3); else passed++;
    @(posedge clk); #1 rstn = 1'b1;
    rd2[47:24] = 24'h5A5A5A;
    rv2 = 2'b10;
    @(posedge clk); #1;
    rv2 = 2'b10;
    @(negedge clk);
    checks++; if (mv2 !== 1'b1) $display("FAIL hold_mvalid: got %b, required 1", mv2); else passed++;
    checks++; if (gid2 !== 1'b1) $display("FAIL hold_gid: got %0d, required 1", gid2); else passed++;
    checks++; if (md2 !== 24'h5A5A5A) $display("FAIL hold_mdata: got %h, required 5a5a5a", md2); else passed++;
    #2 rstn = 1'b0;
    #1;
    checks++; if (mv2 !== 1'b0) $display("FAIL midrst_mvalid: got %b, required 0", mv2); else passed++;
    checks++; if (md2 !== 24'h0) $display("FAIL midrst_mdata: got %h, required 0", md2); else passed++;
    checks++; if (gid2 !== 1'b0) $display("FAIL midrst_gid: got %0d, required 0", gid2); else passed++;
    checks++; if (rr2 !== 2'b00) $display("FAIL midrst_ready: got %b, required 00", rr2); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    rd2[23:0] = 24'hA5B6C7;
    rv2 = 2'b01; mr2 = 1'b1;
    @(negedge clk);
    checks++; if (rr2 !== 2'b01) $display("FAIL single_ready: got %b, required 01", rr2); else passed++;
    @(posedge clk); #1 rv2 = 2'b00;
    @(negedge clk);
    checks++; if (mv2 !== 1'b1) $display("FAIL single_mvalid: got %b, required 1", mv2); else passed++;
    checks++; if (md2 !== 24'hA5B6C7) $display("FAIL single_mdata: got %h, required a5b6c7", md2); else passed++;
    checks++; if (gid2 !== 1'b0) $display("FAIL single_gid: got %0d, required 0", gid2); else passed++;
    checks++; if (rr2 !== 2'b00) $display("FAIL single_hold_ready: got %b, required 00", rr2); else passed++;
    @(negedge clk);
    checks++; if (mv2 !== 1'b0) $display("FAIL single_done: got %b, required 0", mv2); else passed++;
  endtask

  task automatic test_fairness();
    int exp_f[4];
    exp_f = '{0, 1, 0, 1};
    do_reset();
    rv2 = 2'b11; mr2 = 1'b1;
    collect2(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_f[i]) $display("FAIL fair_grant%0d: got %0d, required %0d", i, got[i], exp_f[i]);
      else passed++;
    end
  endtask

  task automatic test_burst();
    int exp_b[7];
`ifdef UART_ARB_BURST_EN
    exp_b = '{0, 0, 0, 1, 1, 1, 0};
`else
    exp_b = '{0, 1, 0, 1, 0, 1, 0};
`endif
    do_reset();
    rv2 = 2'b11; mr2 = 1'b1;
    collect2(7);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) $display("FAIL burst_grant%0d: got %0d, required %0d", i, got[i], exp_b[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic ok_v, ok_d, ok_g, ok_r;
    int hs_cnt;
    ok_v = 1'b1; ok_d = 1'b1; ok_g = 1'b1; ok_r = 1'b1;
    do_reset();
    rd2[23:0] = 24'h0F1E2D;
    rv2 = 2'b01; mr2 = 1'b0;
    @(posedge clk); #1 rv2 = 2'b11;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mv2 !== 1'b1) ok_v = 1'b0;
      if (md2 !== 24'h0F1E2D) ok_d = 1'b0;
      if (gid2 !== 1'b0) ok_g = 1'b0;
      if (rr2 !== 2'b00) ok_r = 1'b0;
    end
    checks++; if (ok_v !== 1'b1) $display("FAIL bp_mvalid: last got %b, required 1", mv2); else passed++;
    checks++; if (ok_d !== 1'b1) $display("FAIL bp_mdata: last got %h, required 0f1e2d", md2); else passed++;
    checks++; if (ok_g !== 1'b1) $display("FAIL bp_gid: last got %0d, required 0", gid2); else passed++;
    checks++; if (ok_r !== 1'b1) $display("FAIL bp_ready: last got %b, required 00", rr2); else passed++;
    @(posedge clk); #1 rv2 = 2'b00; mr2 = 1'b1;
    hs_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mv2 && mr2) hs_cnt++;
    end
    checks++; if (hs_cnt !== 1) $display("FAIL bp_handshakes: got %0d, required 1", hs_cnt); else passed++;
    checks++; if (mv2 !== 1'b0) $display("FAIL bp_idle: got %b, required 0", mv2); else passed++;
  endtask

  task automatic test_wrap3();
    int exp_w[4];
    exp_w = '{0, 1, 2, 0};
    do_reset();
    rd3 = {24'hC0C0C2, 24'hB0B0B1, 24'hA0A0A0};
    rv3 = 3'b111; mr3 = 1'b1;
    collect3(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) $display("FAIL wrap_grant%0d: got %0d, required %0d", i, got[i], exp_w[i]);
      else passed++;
    end
    do_reset();
    rv3 = 3'b111; mr3 = 1'b1;
    collect3(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp_w[i]) $display("FAIL skip_pre%0d: got %0d, required %0d", i, got[i], exp_w[i]);
      else passed++;
    end
    @(posedge clk); #1 rv3 = 3'b100;
    collect3(1);
    checks++; if (got[0] !== 2) $display("FAIL skip_grant: got %0d, required 2", got[0]); else passed++;
    @(negedge clk);
    checks++; if (gid3 !== 2'd2) $display("FAIL skip_gid: got %0d, required 2", gid3); else passed++;
    checks++; if (md3 !== 24'hC0C0C2) $display("FAIL skip_mdata: got %h, required c0c0c2", md3); else passed++;
    rv3 = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_backpressure();
    test_wrap3();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
